// File: rtl/mem_request_arbiter.sv
// Grant FSM sharing one single-ported RAM between instruction fetch and data accesses.
// Optional ARB_STATS_EN adds completion and stall counters (icnt, dcnt, stallcnt).
module mem_request_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       icnt,
  output logic [31:0]       dcnt,
  output logic [31:0]       stallcnt
`endif
);

  localparam int          SC_W       = $clog2(STARVE_MAX + 1);
  localparam logic [1:0]  RAM_ACCESS = 2'd2;
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [SC_W-1:0] r_starve_cnt;
  logic            w_dreq;
  logic            w_access;
  logic            w_icomp;
  logic            w_dcomp;

  assign w_dreq   = dREN | dWEN;
  assign w_access = (ramstate == RAM_ACCESS);
  // A completion needs the granted requester to still be asking; otherwise it is an abort.
  assign w_icomp  = (r_state == IGNT) & iREN & w_access;
  assign w_dcomp  = (r_state == DGNT) & w_dreq & w_access;

  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    iwait        = ~w_icomp;
    dwait        = ~w_dcomp;
    case (r_state)
      IDLE: begin
        if (w_dreq && iREN)  w_next_state = (r_starve_cnt == SC_MAX) ? IGNT : DGNT;
        else if (w_dreq)     w_next_state = DGNT;
        else if (iREN)       w_next_state = IGNT;
      end
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN || w_icomp) w_next_state = IDLE;
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!w_dreq || w_dcomp) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Counts data wins while fetch waits; saturates so fetch is forced at STARVE_MAX.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                  r_starve_cnt <= '0;
    else if (!iREN || w_icomp)                  r_starve_cnt <= '0;
    else if (w_dcomp && r_starve_cnt != SC_MAX) r_starve_cnt <= r_starve_cnt + SC_W'(1);
  end

`ifdef ARB_STATS_EN
  logic [31:0] r_icnt;
  logic [31:0] r_dcnt;
  logic [31:0] r_stallcnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_icnt     <= '0;
      r_dcnt     <= '0;
      r_stallcnt <= '0;
    end else begin
      if (w_icomp) r_icnt <= r_icnt + 32'd1;
      if (w_dcomp) r_dcnt <= r_dcnt + 32'd1;
      if ((iREN | w_dreq) && !(w_icomp | w_dcomp)) r_stallcnt <= r_stallcnt + 32'd1;
    end
  end

  assign icnt     = r_icnt;
  assign dcnt     = r_dcnt;
  assign stallcnt = r_stallcnt;
`endif

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Scoreboard bench for mem_request_arbiter: transaction-level arbitration model plus
// randomized RAM latency; a negedge monitor checks every completion against the queue.
module tb_mem_request_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 2;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          iREN, dREN, dWEN;
  logic [AW-1:0] iaddr, daddr, ramaddr;
  logic [DW-1:0] dstore, iload, dload, ramstore, ramload;
  logic          iwait, dwait, ramREN, ramWEN;
  logic [1:0]    ramstate;
`ifdef ARB_STATS_EN
  logic [31:0]   icnt, dcnt, stallcnt;
`endif

  mem_request_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef ARB_STATS_EN
    , .icnt(icnt), .dcnt(dcnt), .stallcnt(stallcnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          side;   // 1 = data, 0 = instruction
    logic [31:0] addr;
    bit          ren;
    bit          wen;
    logic [31:0] store;
    logic [31:0] load;
  } exp_t;

  exp_t sb_q[$];
  bit   act_sides[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model: what each requester is currently asking for
  bit          m_i_pend;
  logic [31:0] m_i_addr;
  bit          m_d_ren, m_d_wen;
  logic [31:0] m_d_addr, m_d_data;
  int          m_starve;
  int          exp_icnt, exp_dcnt, exp_stall;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (nRST === 1'b1 && (iwait === 1'b0 || dwait === 1'b0)) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_completion: iwait=%b dwait=%b, no access expected (t=%0t)",
                 iwait, dwait, $time);
      end else begin
        exp_t e;
        bit   side;
        e    = sb_q.pop_front();
        side = (dwait === 1'b0);
        act_sides.push_back(side);
        chk1("comp_side", side, e.side);
        chk1("comp_other_wait", side ? iwait : dwait, 1'b1);
        chk32("comp_ramaddr", ramaddr, e.addr);
        chk1("comp_ramREN", ramREN, e.ren);
        chk1("comp_ramWEN", ramWEN, e.wen);
        if (side) chk32("comp_ramstore", ramstore, e.store);
        chk32("comp_load", side ? dload : iload, e.load);
      end
    end
  end

  task automatic drive_inputs();
    iREN   = m_i_pend;
    iaddr  = m_i_addr;
    dREN   = m_d_ren;
    dWEN   = m_d_wen;
    daddr  = m_d_addr;
    dstore = m_d_data;
  endtask

  task automatic new_i();
    m_i_pend = 1'b1;
    m_i_addr = $urandom;
  endtask

  // kind 0 = read, 1 = write, 2 = both enables (write takes precedence)
  task automatic new_d(input int kind);
    m_d_ren  = (kind != 1);
    m_d_wen  = (kind != 0);
    m_d_addr = $urandom;
    m_d_data = $urandom;
  endtask

  // Called at posedge+1 of a cycle in which the arbiter sits in IDLE.
  // wmode: 0 BUSY, 1 ERROR, 2 random non-ACCESS; reissue: 0 random, 1 renew winner, 2 drop winner
  task automatic do_round(input int nwait, input int wmode, input logic [31:0] load, input int reissue);
    bit         dp, win_d;
    exp_t       e;
    logic [1:0] ws;
    int         idx;
    dp = m_d_ren | m_d_wen;
    drive_inputs();
    if (!m_i_pend) m_starve = 0;
    if (!m_i_pend && !dp) begin
      @(negedge CLK);
      chk1("noreq_ramREN", ramREN, 1'b0);
      chk1("noreq_ramWEN", ramWEN, 1'b0);
      @(posedge CLK); #1;
      if (reissue == 0) begin
        if ($urandom % 2 == 1) new_i();
        if ($urandom % 2 == 1) new_d($urandom % 3);
      end
      drive_inputs();
      return;
    end
    win_d   = dp && (!m_i_pend || m_starve < SMAX);
    e.side  = win_d;
    e.addr  = win_d ? m_d_addr : m_i_addr;
    e.wen   = win_d && m_d_wen;
    e.ren   = win_d ? (m_d_ren && !m_d_wen) : 1'b1;
    e.store = win_d ? m_d_data : 32'd0;
    e.load  = load;
    exp_stall += 1 + nwait;

    @(negedge CLK);
    chk1("idle_ramREN", ramREN, 1'b0);
    chk1("idle_ramWEN", ramWEN, 1'b0);
    chk1("idle_iwait", iwait, 1'b1);
    chk1("idle_dwait", dwait, 1'b1);
    for (int k = 0; k < nwait; k++) begin
      @(posedge CLK); #1;
      idx = $urandom % 3;
      ws  = (wmode == 0) ? 2'd1 : (wmode == 1) ? 2'd3 :
            (idx == 0) ? 2'd0 : (idx == 1) ? 2'd1 : 2'd3;
      ramstate = ws;
      ramload  = $urandom;
      @(negedge CLK);
      chk32("hold_ramaddr", ramaddr, e.addr);
      chk1("hold_ramREN", ramREN, e.ren);
      chk1("hold_ramWEN", ramWEN, e.wen);
      chk1("hold_iwait", iwait, 1'b1);
      chk1("hold_dwait", dwait, 1'b1);
    end
    @(posedge CLK); #1;
    ramstate = 2'd2;
    ramload  = load;
    sb_q.push_back(e);
    @(negedge CLK);
    chk32("access_ramaddr", ramaddr, e.addr);
    chk1("access_ramREN", ramREN, e.ren);
    chk1("access_ramWEN", ramWEN, e.wen);
    @(posedge CLK); #1;
    ramstate = 2'd0;

    if (win_d) begin
      exp_dcnt++;
      m_starve = m_i_pend ? ((m_starve + 1 > SMAX) ? SMAX : m_starve + 1) : 0;
      if (reissue == 1 || (reissue == 0 && $urandom % 2 == 1)) new_d($urandom % 3);
      else begin m_d_ren = 1'b0; m_d_wen = 1'b0; end
      if (reissue == 0 && !m_i_pend && $urandom % 2 == 1) new_i();
    end else begin
      exp_icnt++;
      m_starve = 0;
      if (reissue == 1 || (reissue == 0 && $urandom % 2 == 1)) new_i();
      else m_i_pend = 1'b0;
      if (reissue == 0 && !(m_d_ren | m_d_wen) && $urandom % 2 == 1) new_d($urandom % 3);
    end
    drive_inputs();
  endtask

  task automatic clear_model();
    m_i_pend = 1'b0; m_i_addr = '0;
    m_d_ren  = 1'b0; m_d_wen  = 1'b0; m_d_addr = '0; m_d_data = '0;
    m_starve = 0; exp_icnt = 0; exp_dcnt = 0; exp_stall = 0;
  endtask

  task automatic reset_dut();
    @(posedge CLK); #1;
    nRST = 1'b0;
    clear_model();
    drive_inputs();
    ramstate = 2'd0;
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  initial begin
    bit pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int base;
    nRST = 1'b0;
    clear_model();
    drive_inputs();
    ramstate = 2'd0;
    ramload  = '0;

    #12;
    chk1("rst_ramREN", ramREN, 1'b0);
    chk1("rst_ramWEN", ramWEN, 1'b0);
    chk32("rst_ramaddr", ramaddr, 32'd0);
    chk32("rst_ramstore", ramstore, 32'd0);
    chk1("rst_iwait", iwait, 1'b1);
    chk1("rst_dwait", dwait, 1'b1);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // reset asserted mid-way through a data grant
    m_d_ren = 1'b1; m_d_addr = 32'h300;
    drive_inputs();
    @(negedge CLK);
    chk1("pre_rst_idle_ramREN", ramREN, 1'b0);
    @(posedge CLK); #1;
    ramstate = 2'd1;
    @(negedge CLK);
    chk1("pre_rst_dgnt_ramREN", ramREN, 1'b1);
    #2 nRST = 1'b0;
    #1;
    chk1("midrst_ramREN", ramREN, 1'b0);
    chk1("midrst_ramWEN", ramWEN, 1'b0);
    chk32("midrst_ramaddr", ramaddr, 32'd0);
    chk1("midrst_iwait", iwait, 1'b1);
    chk1("midrst_dwait", dwait, 1'b1);
    @(posedge CLK); #1;
    ramstate = 2'd0;
    nRST = 1'b1;
    @(negedge CLK);
    chk1("post_rst_idle_ramREN", ramREN, 1'b0);
    reset_dut();

    // 3 data + 2 instruction accesses, one BUSY cycle each
    for (int k = 0; k < 5; k++) begin
      if (k < 3) new_d(k);
      else new_i();
      do_round(1, 0, $urandom, 2);
    end
`ifdef ARB_STATS_EN
    chk32("stats_icnt", icnt, 32'(exp_icnt));
    chk32("stats_dcnt", dcnt, 32'(exp_dcnt));
    chk32("stats_stallcnt", stallcnt, 32'(exp_stall));
`endif

    m_i_pend = 1'b1; m_i_addr = 32'h100;
    do_round(2, 0, 32'hDEADBEEF, 2);

    // contention: write versus fetch in IDLE
    m_i_pend = 1'b1; m_i_addr = 32'h180;
    m_d_ren = 1'b0; m_d_wen = 1'b1; m_d_addr = 32'h200; m_d_data = 32'h55;
    base = act_sides.size();
    do_round(0, 0, $urandom, 2);
    do_round(0, 0, $urandom, 2);
    if (act_sides.size() < base + 2) begin
      n_checks++; n_errors++;
      $display("FAIL contention_count: got %0d completions expected 2", act_sides.size() - base);
    end else begin
      chk1("contention_first", act_sides[base], 1'b1);
      chk1("contention_second", act_sides[base+1], 1'b0);
    end

    reset_dut();
    new_i();
    new_d(0);
    base = act_sides.size();
    for (int k = 0; k < 6; k++) do_round(0, 0, $urandom, 1);
    if (act_sides.size() < base + 6) begin
      n_checks++; n_errors++;
      $display("FAIL starve_count: got %0d completions expected 6", act_sides.size() - base);
    end else begin
      for (int k = 0; k < 6; k++) chk1("starve_order", act_sides[base+k], pat[k]);
    end

    reset_dut();
    new_d(0);
    do_round(1, 1, $urandom, 2);

    // abort: data read dropped before ACCESS
    m_d_ren = 1'b1; m_d_addr = 32'h400;
    drive_inputs();
    @(negedge CLK);
    chk1("abort_idle_ramREN", ramREN, 1'b0);
    @(posedge CLK); #1;
    ramstate = 2'd1;
    @(negedge CLK);
    chk1("abort_grant_ramREN", ramREN, 1'b1);
    @(posedge CLK); #1;
    m_d_ren = 1'b0;
    drive_inputs();
    @(negedge CLK);
    chk1("abort_ramREN", ramREN, 1'b0);
    chk1("abort_dwait", dwait, 1'b1);
    @(posedge CLK); #1;
    ramstate = 2'd0;
    new_d(0);
    do_round(0, 0, $urandom, 2);

    for (int r = 0; r < 60; r++) do_round($urandom % 4, 2, $urandom, 0);

    clear_model();
    drive_inputs();
    repeat (3) @(posedge CLK);
    #1;
    chk32("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
